// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/funct encodings, ALU codes, FSM state codes and the control
// bundle passed from the instruction decoder to the sequencer.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_RTYPE = 3'd1,
    K_LW    = 3'd2,
    K_SW    = 3'd3,
    K_ADDI  = 3'd4,
    K_BEQ   = 3'd5,
    K_HALT  = 3'd6
  } instr_kind_e;

  typedef struct packed {
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic [3:0]  alu_ctrl;
    instr_kind_e kind;
  } ctrl_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory.
// Handshake: the master holds fetch_req and fetch_addr stable while waiting;
// a word transfers on a rising edge where fetch_req and fetch_valid are both 1,
// and fetch_valid while fetch_req is 0 is ignored.
interface datapath_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                fetch_req;
  logic [PC_WIDTH-1:0] fetch_addr;
  logic                fetch_valid;
  logic [31:0]         fetch_data;

  modport master (output fetch_req, fetch_addr, input fetch_valid, fetch_data);
  modport slave  (input fetch_req, fetch_addr, output fetch_valid, fetch_data);
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of opcode/funct into the DataPath control bundle,
// flagging anything outside the supported instruction subset as illegal.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.reg_dst = 1'b1;
        o_ctrl.kind    = K_RTYPE;
        case (i_funct)
          FN_ADD:  o_ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  o_ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  o_ctrl.alu_ctrl = ALU_AND;
          FN_OR:   o_ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  o_ctrl.alu_ctrl = ALU_SLT;
          default: begin
            o_ctrl    = '0;
            o_illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_ctrl   = ALU_ADD;
        o_ctrl.kind       = K_LW;
      end
      OP_SW: begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_ctrl = ALU_ADD;
        o_ctrl.kind     = K_SW;
      end
      OP_ADDI: begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu_ctrl = ALU_ADD;
        o_ctrl.kind     = K_ADDI;
      end
      OP_BEQ: begin
        o_ctrl.alu_ctrl = ALU_SUB;
        o_ctrl.kind     = K_BEQ;
      end
      OP_HALT: o_ctrl.kind = K_HALT;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM driving the single-cycle
// DataPath; owns the PC, branch resolution, memory wait/timeout and retire count.
module datapath_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  datapath_sequencer_if.master  fetch_if,
  input  logic                  mem_ack,
  input  logic                  zero,
  output logic [25:0]           Instruction,
  output logic                  RegDst,
  output logic                  ALUSrc,
  output logic                  MemToReg,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [3:0]            ALUControl_Signal,
  output logic                  halted,
  output logic                  illegal,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  retired,
  output logic [2:0]            o_state
);

  localparam int              TW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LIM = TW'(MEM_TIMEOUT - 1);

  logic [2:0]           r_state;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [31:0]          r_instr;
  ctrl_t                r_ctrl;
  logic [TW-1:0]        r_mem_cnt;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_halted;
  logic                 r_illegal;
  logic                 r_timeout;

  ctrl_t                w_dec_ctrl;
  logic                 w_dec_illegal;
  ctrl_t                w_ctrl;
  logic [31:0]          w_off32;
  logic [PC_WIDTH-1:0]  w_pc_plus4;
  logic [PC_WIDTH-1:0]  w_pc_branch;

  instr_decoder u_dec (
    .i_opcode  (r_instr[31:26]),
    .i_funct   (r_instr[5:0]),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

  assign w_off32     = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_pc_plus4  = r_pc + PC_WIDTH'(4);
  assign w_pc_branch = w_pc_plus4 + PC_WIDTH'($signed(w_off32));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= PC_WIDTH'(RESET_PC);
      r_instr   <= '0;
      r_ctrl    <= '0;
      r_mem_cnt <= '0;
      r_retired <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (fetch_if.fetch_valid) begin
            r_instr <= fetch_if.fetch_data;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_dec_illegal) begin
            r_illegal <= 1'b1;
            r_pc      <= w_pc_plus4;
            r_state   <= ST_FETCH;
          end else begin
            r_ctrl  <= w_dec_ctrl;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_mem_cnt <= '0;
          case (r_ctrl.kind)
            K_BEQ: begin
              r_pc      <= zero ? w_pc_branch : w_pc_plus4;
              r_retired <= r_retired + 1'b1;
              r_ctrl    <= '0;
              r_state   <= ST_FETCH;
            end
            K_LW, K_SW: r_state <= ST_MEM;
            K_HALT: begin
              r_halted <= 1'b1;
              r_ctrl   <= '0;
              r_state  <= ST_HALT;
            end
            default: r_state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (r_ctrl.kind == K_LW) begin
              r_state <= ST_WB;
            end else begin
              r_retired <= r_retired + 1'b1;
              r_pc      <= w_pc_plus4;
              r_ctrl    <= '0;
              r_state   <= ST_FETCH;
            end
          end else if (r_mem_cnt == T_LIM) begin
            // Abandon the access: skip the instruction without retiring it.
            r_timeout <= 1'b1;
            r_pc      <= w_pc_plus4;
            r_ctrl    <= '0;
            r_state   <= ST_FETCH;
          end else begin
            r_mem_cnt <= r_mem_cnt + 1'b1;
          end
        end
        ST_WB: begin
          r_retired <= r_retired + 1'b1;
          r_pc      <= w_pc_plus4;
          r_ctrl    <= '0;
          r_state   <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // In DECODE the bundle comes straight from the decoder; afterwards from r_ctrl.
  assign w_ctrl = (r_state == ST_DECODE) ? w_dec_ctrl : r_ctrl;

  assign fetch_if.fetch_req  = (r_state == ST_FETCH);
  assign fetch_if.fetch_addr = r_pc;

  assign Instruction       = r_instr[25:0];
  assign RegDst            = w_ctrl.reg_dst;
  assign ALUSrc            = w_ctrl.alu_src;
  assign MemToReg          = w_ctrl.mem_to_reg;
  assign ALUControl_Signal = w_ctrl.alu_ctrl;
  assign MemRead           = ((r_state == ST_MEM) || (r_state == ST_WB)) && (r_ctrl.kind == K_LW);
  assign MemWrite          = (r_state == ST_MEM) && (r_ctrl.kind == K_SW);
  assign RegWrite          = (r_state == ST_WB);
  assign halted            = r_halted;
  assign illegal           = r_illegal;
  assign timeout           = r_timeout;
  assign retired           = r_retired;
  assign o_state           = r_state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: runs hand-decoded instructions and
// checks latencies, enable pulse counts, PC updates and retire counts.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ack;
  logic        zero;
  logic [25:0] Instruction;
  logic        RegDst, ALUSrc, MemToReg, MemRead, MemWrite, RegWrite;
  logic [3:0]  ALUControl_Signal;
  logic        halted, illegal, timeout;
  logic [15:0] retired;
  logic [2:0]  state;

  datapath_sequencer_if #(.PC_WIDTH(32)) fif ();

  datapath_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_if          (fif),
    .mem_ack           (mem_ack),
    .zero              (zero),
    .Instruction       (Instruction),
    .RegDst            (RegDst),
    .ALUSrc            (ALUSrc),
    .MemToReg          (MemToReg),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .RegWrite          (RegWrite),
    .ALUControl_Signal (ALUControl_Signal),
    .halted            (halted),
    .illegal           (illegal),
    .timeout           (timeout),
    .retired           (retired),
    .o_state           (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pc(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected-PC queue empty, got 0x%0h", tag, fif.fetch_addr);
    end else begin
      e = exp_q.pop_front();
      check(tag, fif.fetch_addr, e);
    end
  endtask

  // ---------------- driver ----------------
  int   cyc, n_rw, n_mr, n_mw, n_both, n_to, n_il, rw_at, ack_at_cyc;
  logic snap_regdst, snap_alusrc, snap_memtoreg;
  logic [3:0]  snap_alu;
  logic [25:0] snap_instr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    fif.fetch_valid = 1'b0;
    fif.fetch_data  = '0;
    mem_ack         = 1'b0;
    zero            = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // Presents one instruction and steps until fetch_req returns, halted rises
  // or max_cyc elapses. The memory model acks in the ack_at-th access cycle.
  task automatic exec_instr(input logic [31:0] instr, input int fetch_wait,
                            input int ack_at, input logic z, input bit spurious,
                            input int max_cyc);
    int mem_cyc;
    bit done;
    mem_cyc = 0; done = 1'b0;
    cyc = 0; n_rw = 0; n_mr = 0; n_mw = 0; n_both = 0; n_to = 0; n_il = 0;
    rw_at = -1; ack_at_cyc = -1;
    zero = z;
    mem_ack = 1'b0;
    repeat (fetch_wait) begin
      step();
      cyc++;
    end
    fif.fetch_valid = 1'b1;
    fif.fetch_data  = instr;
    while (!done && cyc < max_cyc) begin
      step();
      cyc++;
      if (spurious) fif.fetch_data = 32'hFC00_0000;
      else fif.fetch_valid = 1'b0;
      if (cyc == fetch_wait + 1) begin
        snap_regdst   = RegDst;
        snap_alusrc   = ALUSrc;
        snap_memtoreg = MemToReg;
        snap_alu      = ALUControl_Signal;
        snap_instr    = Instruction;
      end
      if (RegWrite) begin n_rw++; rw_at = cyc; end
      if (MemRead) n_mr++;
      if (MemWrite) n_mw++;
      if (RegWrite && MemWrite) n_both++;
      if (timeout) n_to++;
      if (illegal) n_il++;
      if (MemRead || MemWrite) mem_cyc++;
      mem_ack = (ack_at != 0) && (MemRead || MemWrite) && (mem_cyc == ack_at);
      if (mem_ack) ack_at_cyc = cyc;
      if (fif.fetch_req || halted) done = 1'b1;
    end
    fif.fetch_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int any_req;
    exp_q = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h0C, 32'h10, 32'h14,
              32'h18, 32'h1C, 32'h20, 32'h24};

    do_reset();
    check("rst_fetch_req", fif.fetch_req, 1);
    check("rst_pc", fif.fetch_addr, 0);
    check("rst_retired", retired, 0);
    check("rst_halted", halted, 0);
    check("rst_enables", {RegWrite, MemWrite, MemRead}, 0);
    check("rst_selects", {RegDst, ALUSrc, MemToReg, ALUControl_Signal}, 0);
    check("rst_instr", Instruction, 0);
    check("rst_state", state, 0);

    // add $1,$2,$3
    exec_instr(32'h0043_0820, 0, 0, 1'b0, 1'b0, 40);
    check("add_cycles", cyc, 4);
    check("add_regdst", snap_regdst, 1);
    check("add_alu", snap_alu, 4'b0101);
    check("add_instr", snap_instr, 26'h043_0820);
    check("add_regwrite_cnt", n_rw, 1);
    check("add_regwrite_at", rw_at, 3);
    check_pc("add_pc");
    check("add_retired", retired, 1);

    // lw $1,4($2), ack in 4th MEM cycle
    exec_instr(32'h8C41_0004, 0, 4, 1'b0, 1'b0, 40);
    check("lw_cycles", cyc, 8);
    check("lw_memread_cnt", n_mr, 5);
    check("lw_memtoreg", snap_memtoreg, 1);
    check("lw_alusrc", snap_alusrc, 1);
    check("lw_alu", snap_alu, 4'b0101);
    check("lw_regwrite_cnt", n_rw, 1);
    check("lw_rw_after_ack", rw_at, ack_at_cyc + 1);
    check_pc("lw_pc");
    check("lw_retired", retired, 2);

    // sw $1,8($2), never acked
    exec_instr(32'hAC41_0008, 0, 0, 1'b0, 1'b0, 60);
    check("swto_cycles", cyc, 18);
    check("swto_memwrite_cnt", n_mw, 15);
    check("swto_timeout_cnt", n_to, 1);
    check("swto_regwrite_cnt", n_rw, 0);
    check_pc("swto_pc");
    check("swto_retired", retired, 2);

    // sw acked in first MEM cycle
    exec_instr(32'hAC41_0008, 0, 1, 1'b0, 1'b0, 40);
    check("sw_cycles", cyc, 4);
    check("sw_memwrite_cnt", n_mw, 1);
    check_pc("sw_pc");
    check("sw_retired", retired, 3);

    // beq at 0x10, imm=-2, taken
    exec_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 40);
    check("beq_t_cycles", cyc, 3);
    check("beq_alu", snap_alu, 4'b0110);
    check("beq_alusrc", snap_alusrc, 0);
    check_pc("beq_t_pc");
    check("beq_t_retired", retired, 4);

    exec_instr(32'h0043_0820, 0, 0, 1'b0, 1'b0, 40);
    check_pc("add2_pc");

    // beq at 0x10 not taken
    exec_instr(32'h1000_FFFE, 0, 0, 1'b0, 1'b0, 40);
    check_pc("beq_nt_pc");
    check("beq_nt_retired", retired, 6);

    // illegal opcode 0x02, then R-type with unsupported funct 0
    exec_instr(32'h0800_0000, 0, 0, 1'b0, 1'b0, 40);
    check("ill_op_cycles", cyc, 2);
    check("ill_op_pulse", n_il, 1);
    check_pc("ill_op_pc");
    exec_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 40);
    check("ill_fn_pulse", n_il, 1);
    check_pc("ill_fn_pc");
    check("ill_retired", retired, 6);

    // addi $1,$0,5
    exec_instr(32'h2001_0005, 0, 0, 1'b0, 1'b0, 40);
    check("addi_cycles", cyc, 4);
    check("addi_alusrc", snap_alusrc, 1);
    check("addi_regdst", snap_regdst, 0);
    check_pc("addi_pc");

    // add with two fetch wait cycles and fetch_valid held high afterwards
    exec_instr(32'h0043_0820, 2, 0, 1'b0, 1'b1, 40);
    check("addw_cycles", cyc, 6);
    check("addw_halted", halted, 0);
    check_pc("addw_pc");
    check("addw_retired", retired, 8);

    // reset in the middle of a lw MEM phase
    exec_instr(32'h8C41_0004, 0, 0, 1'b0, 1'b0, 5);
    check("lwrst_memread_before", MemRead, 1);
    rst = 1'b1;
    step();
    check("lwrst_memread", MemRead, 0);
    check("lwrst_state", state, 0);
    check("lwrst_pc", fif.fetch_addr, 0);
    check("lwrst_retired", retired, 0);
    rst = 1'b0;

    // halt is sticky and ignores fetch_valid until reset
    exec_instr(32'h0043_0820, 0, 0, 1'b0, 1'b0, 40);
    exec_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0, 40);
    check("halt_cycles", cyc, 3);
    check("halt_flag", halted, 1);
    any_req = 0;
    fif.fetch_valid = 1'b1;
    fif.fetch_data  = 32'h0043_0820;
    repeat (6) begin
      step();
      if (fif.fetch_req || !halted || RegWrite || MemRead || MemWrite) any_req++;
    end
    fif.fetch_valid = 1'b0;
    check("halt_stays", any_req, 0);
    check("halt_retired", retired, 1);
    check("halt_pc_held", fif.fetch_addr, 4);
    check("never_rw_and_mw", n_both, 0);
    do_reset();
    check("halt_rst_halted", halted, 0);
    check("halt_rst_pc", fif.fetch_addr, 0);
    check("halt_rst_req", fif.fetch_req, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control FSM that sequences the single-cycle DataPath block.
- Fetches a 32-bit instruction through a valid/ready handshake and latches it.
- Decodes the opcode/funct and drives DataPath control lines phase by phase, so RegWrite and MemWrite pulse only in their own cycle.
- Owns the PC, branch resolution via DataPath `zero`, data-memory wait states, and a retired-instruction counter.
- Sits between instruction memory and DataPath inside the CPU top level.

Parameters:
- PC_WIDTH, 32, width of program counter and fetch address.
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, max MEM-state cycles waiting for mem_ack before abort; counter width is clog2(MEM_TIMEOUT+1).
- CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- fetch_req  out  1  request instruction at fetch_addr
- fetch_addr  out  PC_WIDTH  current PC
- fetch_valid  in  1  fetch_data valid this cycle
- fetch_data  in  32  instruction word
- mem_ack  in  1  data memory completed read/write
- zero  in  1  DataPath ALU zero flag
- Instruction  out  26  latched instr[25:0] to DataPath
- RegDst, ALUSrc, MemToReg  out  1 each  DataPath mux selects
- MemRead, MemWrite, RegWrite  out  1 each  DataPath enables
- ALUControl_Signal  out  4  ALU operation
- halted  out  1  HALT executed; sticky until rst
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- timeout  out  1  one-cycle pulse on mem_ack timeout
- retired  out  CNT_WIDTH  instructions completed; wraps modulo 2^CNT_WIDTH

Behaviour:
Reset:
- Takes effect at the next clk edge, including mid-instruction or mid-MEM.
- State=FETCH, PC=RESET_PC.
- All enables, selects, Instruction, ALUControl_Signal=0; retired=0; halted/illegal/timeout=0.

States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - fetch_req=1.
  - On fetch_valid, latch fetch_data into the instruction register and go to DECODE.
  - fetch_valid without fetch_req is ignored.
- DECODE (1 cycle): latch opcode [31:26] and funct [5:0], then drive selects and ALUControl.
  - R-type (000000) supported functs: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
  - 100011 lw; 101011 sw; 001000 addi; 000100 beq; 111111 halt.
  - Any other opcode/funct: pulse illegal, PC+=4, no retire, return to FETCH.
- Control values held from DECODE until instruction end:
  - R-type: RegDst=1, ALUSrc=0, MemToReg=0.
  - lw: RegDst=0, ALUSrc=1, MemToReg=1, ALU=ADD.
  - sw: ALUSrc=1, ALU=ADD.
  - addi: RegDst=0, ALUSrc=1, MemToReg=0, ALU=ADD.
  - beq: ALUSrc=0, ALU=SUB.
- EXEC (1 cycle): ALU settles.
  - beq: if zero, PC = PC + 4 + (sign-extend(imm16)<<2) mod 2^PC_WIDTH; else PC+=4. Retire, go to FETCH.
  - lw/sw go to MEM; R-type/addi go to WB; halt goes to HALT.
- MEM:
  - lw drives MemRead=1; sw drives MemWrite=1, held until mem_ack.
  - On mem_ack: lw goes to WB; sw retires, PC+=4, FETCH.
  - mem_ack arriving in the first MEM cycle is accepted.
  - After MEM_TIMEOUT cycles without ack: pulse timeout, deassert, PC+=4, no retire, FETCH.
- WB (1 cycle): RegWrite=1, MemRead stays 1 for lw. Retire, PC+=4, FETCH.
- HALT: halted=1, all enables 0, fetch_req=0. Only rst exits.
- Minimum latency per instruction:
  - Fetch-to-fetch, fetch_valid in its first FETCH cycle: R-type/addi 4 cycles, beq 3, lw 5, sw 4.
  - Each extra fetch or mem wait cycle adds one.
- RegWrite, MemWrite, MemRead are never 1 outside WB/MEM. RegWrite and MemWrite are never both 1.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - Opcode and funct constants.
  - ALU codes: AND 0000, OR 0001, ADD 0101, SUB 0110, SLT 0111.
  - State enumeration.
- Sub-module instr_decoder: combinational opcode/funct to control bundle plus illegal flag, instantiated in DECODE.

Test Plan:
- add $1,$2,$3 (0x00430820), fetch_valid in first FETCH cycle → RegDst=1, ALUControl=0101; RegWrite high exactly one cycle (WB); fetch_addr 0→4; retired=1.
- lw $1,4($2) with mem_ack 3 cycles after MEM entry → MemRead high for 4 cycles plus WB; MemToReg=1, ALUSrc=1; RegWrite one cycle after ack.
- sw $1,8($2), mem_ack never asserted → MemWrite high 15 cycles, timeout pulse, RegWrite never 1, PC+=4, retired unchanged.
- beq at PC=0x10, imm=0xFFFE, zero=1 → next fetch_addr=0x0C; same with zero=0 → 0x14.
- Opcode 0x3F → halted=1, fetch_req=0 forever; rst then halted=0, fetch_addr=RESET_PC. Opcode 0x02 → illegal pulse, PC+=4.
- rst asserted during MEM of lw → next cycle MemRead=0, state FETCH, PC=0, retired=0.
